stopwatch_ctrl: RTL and testbench

//  Sequencer for the stopwatch display datapath: button-driven run/pause/clear/set FSM,
//  1 Hz tick prescaler, cascaded MM:SS BCD time counters and time-multiplexed 4-digit scan.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/stopwatch_bcd_digit_cnt.sv | 49 ++++
 rtl/stopwatch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module : stopwatch_pkg
// Brief  : Shared types and digit limits for the stopwatch sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      SET   = 2'd3
   } sw_state_t;

   typedef logic [3:0] bcd_t;

   localparam int SU_MAX = 9;
   localparam int ST_MAX = 5;
   localparam int MU_MAX = 9;
   localparam int MT_MAX = 5;

   function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
      digit_onehot = 4'b0001 << idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_bcd_digit_cnt.sv
// ============================================================================
// Module : bcd_digit_cnt
// Brief  : Single BCD digit counter, wraps at MAX, carry when incrementing at MAX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_cnt
   import stopwatch_pkg::*;
#(
   parameter int MAX = 9
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   input  logic load_i,
   input  bcd_t load_val_i,
   output bcd_t val_o,
   output logic carry_o
);

   localparam bcd_t MAX_V = bcd_t'(MAX);

   bcd_t val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (clr_i)
         val_d = '0;
      else if (load_i)
         val_d = load_val_i;
      else if (inc_i)
         val_d = (val_q == MAX_V) ? '0 : val_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         val_q <= '0;
      else
         val_q <= val_d;
   end

   assign val_o   = val_q;
   assign carry_o = inc_i & (val_q == MAX_V);

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module : stopwatch_ctrl
// Brief  : Stopwatch run/pause/clear/set FSM, 1 Hz prescaler, MM:SS counters, digit scan.
//          Optional LAP_HOLD_EN adds btn_lap to freeze the display while counting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int SCAN_DIV = 100_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       btn_set,
   input  logic       btn_inc,
`ifdef LAP_HOLD_EN
   input  logic       btn_lap,
`endif
   output logic [3:0] digit_bcd,
   output logic [3:0] digit_en,
   output logic       running,
   output logic       ovf
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   // bit order: 0 start_stop, 1 clear, 2 set, 3 inc
   logic [3:0] btn_now, btn_q, rise;
   logic       ev_clr, ev_set, ev_ss, ev_inc, lap_rise;

   sw_state_t  state_q, state_d;
   logic [1:0] field_q, field_d;
   logic       clr_all, set_inc, tick;

   logic [PW-1:0] presc_q, presc_d;
   logic [SW-1:0] scan_q, scan_d;
   logic [1:0]    idx_q, idx_d;

   bcd_t su, st, mu, mt;
   logic su_cy, st_cy, mu_cy, mt_cy;
   logic [15:0] live, disp;
   bcd_t        sel;

   logic [3:0] en_q;
   bcd_t       bcd_q;
   logic       running_q, ovf_q;

   assign btn_now = {btn_inc, btn_set, btn_clear, btn_start_stop};
   assign rise    = btn_now & ~btn_q;

`ifdef LAP_HOLD_EN
   logic lap_btn_q;
   assign lap_rise = btn_lap & ~lap_btn_q;
`else
   assign lap_rise = 1'b0;
`endif

   assign ev_clr = rise[1];
   assign ev_set = rise[2] & ~rise[1];
   assign ev_ss  = rise[0] & ~rise[1] & ~rise[2];
   assign ev_inc = rise[3] & ~rise[1] & ~rise[2] & ~rise[0] & ~lap_rise;

   always_comb begin
      state_d = state_q;
      field_d = field_q;
      clr_all = 1'b0;
      case (state_q)
         IDLE: begin
            if (ev_clr)      clr_all = 1'b1;
            else if (ev_set) begin state_d = SET; field_d = 2'd0; end
            else if (ev_ss)  state_d = RUN;
         end
         RUN: begin
            if (ev_ss) state_d = PAUSE;
         end
         PAUSE: begin
            if (ev_clr)      begin state_d = IDLE; clr_all = 1'b1; end
            else if (ev_set) begin state_d = SET; field_d = 2'd0; end
            else if (ev_ss)  state_d = RUN;
         end
         SET: begin
            if (ev_clr) begin
               state_d = IDLE;
               clr_all = 1'b1;
            end else if (ev_set) begin
               if (field_q == 2'd3) state_d = PAUSE;
               else                 field_d = field_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign set_inc = (state_q == SET) & ev_inc;
   assign tick    = (state_q == RUN) && (presc_q == TICK_LAST);

   always_comb begin
      presc_d = presc_q;
      if (clr_all)
         presc_d = '0;
      else if (state_q == RUN)
         presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_comb begin
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
      idx_d  = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
   end

   // Tick carries only cascade in RUN; SET increments stay within their field.
   bcd_digit_cnt #(.MAX(SU_MAX)) u_su (
      .clk(clk), .reset(reset), .inc_i(tick | (set_inc & (field_q == 2'd0))),
      .clr_i(clr_all), .load_i(1'b0), .load_val_i('0), .val_o(su), .carry_o(su_cy));
   bcd_digit_cnt #(.MAX(ST_MAX)) u_st (
      .clk(clk), .reset(reset), .inc_i((tick & su_cy) | (set_inc & (field_q == 2'd1))),
      .clr_i(clr_all), .load_i(1'b0), .load_val_i('0), .val_o(st), .carry_o(st_cy));
   bcd_digit_cnt #(.MAX(MU_MAX)) u_mu (
      .clk(clk), .reset(reset), .inc_i((tick & st_cy) | (set_inc & (field_q == 2'd2))),
      .clr_i(clr_all), .load_i(1'b0), .load_val_i('0), .val_o(mu), .carry_o(mu_cy));
   bcd_digit_cnt #(.MAX(MT_MAX)) u_mt (
      .clk(clk), .reset(reset), .inc_i((tick & mu_cy) | (set_inc & (field_q == 2'd3))),
      .clr_i(clr_all), .load_i(1'b0), .load_val_i('0), .val_o(mt), .carry_o(mt_cy));

   assign live = {mt, mu, st, su};

`ifdef LAP_HOLD_EN
   logic        lap_q, lap_d;
   logic [15:0] snap_q, snap_d;

   always_comb begin
      lap_d  = lap_q;
      snap_d = snap_q;
      if (state_d != RUN) begin
         lap_d = 1'b0;
      end else if ((state_q == RUN) && lap_rise && !rise[0] && !rise[1] && !rise[2]) begin
         lap_d = ~lap_q;
         if (!lap_q) snap_d = live;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lap_q     <= 1'b0;
         snap_q    <= '0;
         lap_btn_q <= 1'b0;
      end else begin
         lap_q     <= lap_d;
         snap_q    <= snap_d;
         lap_btn_q <= btn_lap;
      end
   end

   assign disp = lap_q ? snap_q : live;
`else
   assign disp = live;
`endif

   always_comb begin
      case (idx_q)
         2'd0:    sel = disp[3:0];
         2'd1:    sel = disp[7:4];
         2'd2:    sel = disp[11:8];
         default: sel = disp[15:12];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         btn_q     <= '0;
         state_q   <= IDLE;
         field_q   <= 2'd0;
         presc_q   <= '0;
         scan_q    <= '0;
         idx_q     <= 2'd0;
         en_q      <= 4'b0001;
         bcd_q     <= '0;
         running_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         btn_q     <= btn_now;
         state_q   <= state_d;
         field_q   <= field_d;
         presc_q   <= presc_d;
         scan_q    <= scan_d;
         idx_q     <= idx_d;
         en_q      <= digit_onehot(idx_q);
         bcd_q     <= sel;
         running_q <= (state_d == RUN);
         ovf_q     <= tick & mt_cy;
      end
   end

   assign digit_en  = en_q;
   assign digit_bcd = bcd_q;
   assign running   = running_q;
   assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module : tb_stopwatch_ctrl
// Brief  : Directed self-checking bench for stopwatch_ctrl (TICK_DIV=4, SCAN_DIV=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

   localparam logic [3:0] B_SS  = 4'b0001;
   localparam logic [3:0] B_CLR = 4'b0010;
   localparam logic [3:0] B_SET = 4'b0100;
   localparam logic [3:0] B_INC = 4'b1000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btn = 4'b0;
   logic [3:0] digit_bcd, digit_en;
   logic       running, ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
      .clk(clk),
      .reset(reset),
      .btn_start_stop(btn[0]),
      .btn_clear(btn[1]),
      .btn_set(btn[2]),
      .btn_inc(btn[3]),
      .digit_bcd(digit_bcd),
      .digit_en(digit_en),
      .running(running),
      .ovf(ovf)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // one-cycle pulse followed by one released cycle so the next press is a fresh edge
   task automatic press(input logic [3:0] m);
      btn = m;
      tick();
      btn = 4'b0;
      tick();
   endtask

   task automatic read_display(output logic [15:0] word, output logic [3:0] seen);
      word = '0;
      seen = '0;
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 4; k++)
            if (digit_en == (4'b0001 << k)) begin
               word[k*4 +: 4] = digit_bcd;
               seen[k]        = 1'b1;
            end
         tick();
      end
   endtask

   task automatic test_reset;
      logic [3:0] exp_en;
      reset = 1'b0;
      tick(2);
      n_checks++; if (digit_en !== 4'b0001) begin n_fail++; $display("FAIL reset_en: got %b want 0001", digit_en); end
      n_checks++; if (digit_bcd !== 4'd0) begin n_fail++; $display("FAIL reset_bcd: got %h want 0", digit_bcd); end
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      reset = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         exp_en = 4'b0001 << ((n - 1) / 2);
         n_checks++;
         if ({digit_en, digit_bcd} !== {exp_en, 4'd0}) begin
            n_fail++;
            $display("FAIL scan_seq[%0d]: got en=%b bcd=%h want en=%b bcd=0", n, digit_en, digit_bcd, exp_en);
         end
      end
   endtask

   task automatic test_run;
      logic [15:0] w; logic [3:0] s;
      press(B_SS);
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b want 1", running); end
      tick(39);
      press(B_SS);
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b want 0", running); end
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0010}) begin n_fail++; $display("FAIL run_10s: got %h seen %b want 0010", w, s); end
      // prescaler resumes from its held count: two RUN edges, pause, then one more tick
      press(B_SS);
      press(B_SS);
      press(B_SS);
      press(B_SS);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0011}) begin n_fail++; $display("FAIL presc_hold: got %h seen %b want 0011", w, s); end
   endtask

   task automatic test_run_ignores;
      logic [15:0] w; logic [3:0] s;
      press(B_SS);
      press(B_CLR);
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_ign_clr: got %b want 1", running); end
      press(B_INC);
      press(B_SET);
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_ign_set: got %b want 1", running); end
      press(B_SS);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0013}) begin n_fail++; $display("FAIL run_ign_time: got %h seen %b want 0013", w, s); end
      press(B_CLR);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0000}) begin n_fail++; $display("FAIL pause_clear: got %h seen %b want 0000", w, s); end
   endtask

   task automatic test_set;
      logic [15:0] w; logic [3:0] s;
      press(B_SET);
      repeat (12) press(B_INC);
      press(B_SET);
      repeat (7) press(B_INC);
      press(B_SET);
      press(B_SET);
      press(B_SS);
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL set_ign_ss: got %b want 0", running); end
      press(B_SET);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0012}) begin n_fail++; $display("FAIL set_value: got %h seen %b want 0012", w, s); end
      press(B_SS);
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL set_to_pause: got %b want 1", running); end
      press(B_SS);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0012}) begin n_fail++; $display("FAIL set_hold: got %h seen %b want 0012", w, s); end
   endtask

   task automatic test_wrap;
      logic [15:0] w; logic [3:0] s;
      int hits, at;
      press(B_CLR);
      press(B_SET);
      repeat (8) press(B_INC);
      press(B_SET);
      repeat (5) press(B_INC);
      press(B_SET);
      repeat (9) press(B_INC);
      press(B_SET);
      repeat (5) press(B_INC);
      press(B_SET);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h5958}) begin n_fail++; $display("FAIL preload: got %h seen %b want 5958", w, s); end
      press(B_SS);
      hits = 0;
      at   = -1;
      for (int c = 2; c <= 10; c++) begin
         if (ovf === 1'b1) begin hits++; at = c; end
         tick();
      end
      n_checks++; if (hits !== 1) begin n_fail++; $display("FAIL ovf_count: got %0d want 1", hits); end
      n_checks++; if (at !== 9) begin n_fail++; $display("FAIL ovf_cycle: got %0d want 9", at); end
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL wrap_running: got %b want 1", running); end
      press(B_SS);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0000}) begin n_fail++; $display("FAIL wrap_time: got %h seen %b want 0000", w, s); end
   endtask

   task automatic test_priority;
      logic [15:0] w; logic [3:0] s;
      press(B_CLR);
      press(B_SET);
      repeat (3) press(B_INC);
      repeat (4) press(B_SET);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0003}) begin n_fail++; $display("FAIL prio_load: got %h seen %b want 0003", w, s); end
      press(B_CLR | B_SET | B_SS);
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL prio_running: got %b want 0", running); end
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0000}) begin n_fail++; $display("FAIL prio_clear: got %h seen %b want 0000", w, s); end
      press(B_INC);
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0000}) begin n_fail++; $display("FAIL prio_idle_inc: got %h seen %b want 0000", w, s); end
      press(B_SS);
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL prio_idle_ss: got %b want 1", running); end
   endtask

   task automatic test_reset_midrun;
      logic [15:0] w; logic [3:0] s;
      tick(5);
      reset = 1'b0;
      tick();
      n_checks++;
      if ({digit_en, digit_bcd, running, ovf} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midrun_reset: got en=%b bcd=%h run=%b ovf=%b want 0001/0/0/0", digit_en, digit_bcd, running, ovf);
      end
      reset = 1'b1;
      read_display(w, s);
      n_checks++; if ({s, w} !== {4'hF, 16'h0000}) begin n_fail++; $display("FAIL midrun_time: got %h seen %b want 0000", w, s); end
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL midrun_running: got %b want 0", running); end
   endtask

   initial begin
      test_reset();
      test_run();
      test_run_ignores();
      test_set();
      test_wrap();
      test_priority();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
